mips_fetch_stage: RTL and testbench
===================================

// Module: mips_fetch_stage
// PURPOSE
//  - Instruction-fetch front end of MIPS_Pipeline: owns PC, issues word fetches to instruction memory,
//    buffers returned words in a prefetch FIFO and drives the IF/ID pipeline register consumed by decode.
//  - Absorbs imem wait states and decode stalls; squashes wrong-path words on branch/jump redirect from EX.
// PARAMETERS
//  - RESET_PC    32'h0000_0000  PC loaded on reset; must be word aligned
//  - FIFO_DEPTH  4              prefetch entries; power of 2, >=2
//  - MAX_OUTST   2              max imem requests in flight
// PORTS
//  - clk           in   1   rising-edge clock, single domain
//  - reset         in   1   asynchronous, active-low; 0 = reset asserted
//  - imem_req      out  1   fetch request valid
//  - imem_addr     out  32  fetch byte address, word aligned, bits[1:0]=0
//  - imem_gnt      in   1   request accepted this cycle (imem_req & imem_gnt)
//  - imem_rvalid   in   1   response valid; responses in request order, >=1 cycle after grant
//  - imem_rdata    in   32  instruction word
//  - redir_valid   in   1   EX-stage taken branch/jump
//  - redir_pc      in   32  redirect target; bits[1:0] ignored (forced 0)
//  - id_stall      in   1   hazard unit: hold IF/ID register
//  - if_id_valid   out  1   IF/ID holds a real instruction
//  - if_id_instr   out  32  instruction; 32'h0000_0000 (sll $0,$0,0 = NOP) when invalid
//  - if_id_pc      out  32  address of if_id_instr
//  - if_id_pc4     out  32  if_id_pc + 4, modulo 2^32
// BEHAVIOUR
//  - Reset (async assert, sync-to-clk deassert by caller): fetch PC=RESET_PC, FIFO empty, outstanding=0,
//    discard=0, imem_req=0, imem_addr=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pc=0, if_id_pc4=0.
//    Reset mid-transaction: in-flight responses arriving after deassert are not tracked; the bench
//    holds reset for >=2 cycles with imem idle.
//  - Issue: imem_req=1 when (fifo_count + outstanding) < FIFO_DEPTH and outstanding < MAX_OUTST and not
//    redir_valid. imem_addr=PC. On grant: PC<=PC+4 (wraps 32'hFFFF_FFFC -> 0), outstanding++.
//  - Each queued entry stores {instr, pc}; PC of each request travels in a MAX_OUTST-deep tag queue.
//  - Response: imem_rvalid decrements outstanding; if discard>0 word is dropped and discard--,
//    else {rdata, tag pc} pushed to FIFO. Credit rule guarantees no push when full; push-on-full
//    is a design error (assertion).
//  - IF/ID update when id_stall=0: FIFO non-empty -> pop head into IF/ID, if_id_valid=1;
//    FIFO empty -> bubble: if_id_valid=0, if_id_instr=0, pc fields hold previous value.
//    id_stall=1 -> IF/ID holds all fields, FIFO not popped. Bypass: a response arriving into an empty FIFO
//    is visible to IF/ID no earlier than the next cycle (min fetch-to-IF/ID latency = grant+2 cycles).
//  - Simultaneous grant and response: outstanding unchanged; simultaneous push and pop: count unchanged.
//  - Redirect (highest priority, overrides id_stall): PC<=redir_pc & ~3; FIFO flushed; discard<=outstanding
//    (minus 1 if imem_rvalid same cycle); if_id_valid<=0, if_id_instr<=0; no request issued that cycle.
//    First fetch of target issued the following cycle.
//  - Back-to-back redirects: last one wins; discard accumulates correctly across them.
//  - Outputs are registered; no combinational path from imem_rdata or id_stall to if_id_*.
// CONFIGURATION
//  - FETCH_PERF_EN defined: adds out ports perf_fetched[31:0] (count of words pushed to FIFO) and
//    perf_bubbles[31:0] (cycles with id_stall=0 and FIFO empty); both reset to 0, saturate at 32'hFFFF_FFFF,
//    redirect does not clear them.
//  - Not defined: ports and counters absent; all other behaviour identical.
// TESTING
//  - Reset release, imem_gnt=1 always, rvalid 1 cycle after grant, rdata=addr ->
//    if_id_pc 0,4,8,... consecutive, if_id_valid=1 every cycle from cycle 3, no bubbles.
//  - id_stall=1 for 6 cycles -> IF/ID frozen, FIFO fills to 4, imem_req drops to 0; release ->
//    stalled words drain in order with no loss or duplication.
//  - Redirect to 32'h0000_0100 with 2 requests in flight -> both responses dropped,
//    next valid if_id_pc=32'h100, if_id_pc4=32'h104.
//  - Redirect with id_stall=1 the same cycle -> if_id_valid=0 next cycle (redirect wins).
//  - imem_gnt random 50%, rvalid delay 1-3 cycles -> if_id_pc strictly +4 sequence, none skipped.
//  - PC=32'hFFFF_FFFC fetch -> next fetch address 32'h0000_0000; if_id_pc4 of that word = 0.

Source files
------------

// File: rtl/mips_fetch_stage_if.sv
// Fetch-stage bus bundle: imem request/response channel, EX redirect,
// decode stall and the IF/ID pipeline register contents.
//   master : fetch stage (drives imem_req/imem_addr and if_id_*)
//   slave  : surrounding pipeline / instruction memory
interface mips_fetch_stage_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        id_stall;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_pc4;

  modport master (
    output imem_req, imem_addr,
    input  imem_gnt, imem_rvalid, imem_rdata,
    input  redir_valid, redir_pc, id_stall,
    output if_id_valid, if_id_instr, if_id_pc, if_id_pc4
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_gnt, imem_rvalid, imem_rdata,
    output redir_valid, redir_pc, id_stall,
    input  if_id_valid, if_id_instr, if_id_pc, if_id_pc4
  );
endinterface

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch front end: owns the fetch PC, issues word fetches to
// instruction memory, buffers returned words in a prefetch FIFO and drives
// the IF/ID register. Wrong-path words are squashed on EX redirect.
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   bus    mips_fetch_stage_if.master (imem channel, redirect, stall, IF/ID)
// Optional feature macro FETCH_PERF_EN adds perf_fetched / perf_bubbles
// saturating counters as extra output ports.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned MAX_OUTST  = 2
) (
  input  logic               clk,
  input  logic               reset,
  mips_fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned OUT_W = $clog2(MAX_OUTST + 1);
  localparam int unsigned TAG_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

  logic [31:0]  pc_q;
  fetch_entry_t fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] fifo_cnt_q;
  logic [31:0]  tag_mem [MAX_OUTST];
  logic [TAG_W-1:0] tag_wr_q, tag_rd_q;
  logic [OUT_W-1:0] outst_q;
  logic [OUT_W-1:0] discard_q;

  logic         if_id_valid_q;
  logic [31:0]  if_id_instr_q, if_id_pc_q, if_id_pc4_q;

  logic         req_c, grant_c, rsp_c, push_c, pop_c, empty_c, full_c;
  fetch_entry_t head_c;
  logic [1:0]   unused_redir_lsb_c;

  // Circular advance for the request-tag queue (depth need not be a power of 2)
  function automatic logic [TAG_W-1:0] tag_next(input logic [TAG_W-1:0] p);
    return (32'(p) == MAX_OUTST - 1) ? '0 : p + TAG_W'(1);
  endfunction

  // Credit-based issue, FIFO push/pop qualifiers
  always_comb begin
    empty_c = (fifo_cnt_q == '0);
    full_c  = (32'(fifo_cnt_q) == FIFO_DEPTH);
    req_c   = reset && !bus.redir_valid &&
              ((32'(fifo_cnt_q) + 32'(outst_q)) < FIFO_DEPTH) &&
              (32'(outst_q) < MAX_OUTST);
    grant_c = req_c && bus.imem_gnt;
    rsp_c   = bus.imem_rvalid;
    push_c  = rsp_c && (discard_q == '0) && !bus.redir_valid;
    pop_c   = !bus.redir_valid && !bus.id_stall && !empty_c;
    head_c  = fifo_mem[rd_ptr_q];
  end

  assign unused_redir_lsb_c = bus.redir_pc[1:0];

  assign bus.imem_req    = req_c;
  assign bus.imem_addr   = pc_q;
  assign bus.if_id_valid = if_id_valid_q;
  assign bus.if_id_instr = if_id_instr_q;
  assign bus.if_id_pc    = if_id_pc_q;
  assign bus.if_id_pc4   = if_id_pc4_q;

  // Storage arrays: no reset needed, guarded by pointers/counts
  always_ff @(posedge clk) begin
    if (push_c) fifo_mem[wr_ptr_q] <= '{instr: bus.imem_rdata, pc: tag_mem[tag_rd_q]};
    if (grant_c) tag_mem[tag_wr_q] <= pc_q;
  end

  // PC, in-flight tracking, FIFO control and IF/ID register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q          <= RESET_PC;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      fifo_cnt_q    <= '0;
      tag_wr_q      <= '0;
      tag_rd_q      <= '0;
      outst_q       <= '0;
      discard_q     <= '0;
      if_id_valid_q <= 1'b0;
      if_id_instr_q <= '0;
      if_id_pc_q    <= '0;
      if_id_pc4_q   <= '0;
    end else begin
      if (bus.redir_valid) pc_q <= {bus.redir_pc[31:2], 2'b00};
      else if (grant_c)    pc_q <= pc_q + 32'd4;

      case ({grant_c, rsp_c})
        2'b10:   outst_q <= outst_q + OUT_W'(1);
        2'b01:   outst_q <= outst_q - OUT_W'(1);
        default: outst_q <= outst_q;
      endcase

      // Every word still in flight at redirect time is wrong-path
      if (bus.redir_valid)            discard_q <= rsp_c ? outst_q - OUT_W'(1) : outst_q;
      else if (rsp_c && discard_q != '0) discard_q <= discard_q - OUT_W'(1);

      // Tags pop on every response, dropped or not, to stay in step with imem
      if (grant_c) tag_wr_q <= tag_next(tag_wr_q);
      if (rsp_c)   tag_rd_q <= tag_next(tag_rd_q);

      if (bus.redir_valid) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        fifo_cnt_q <= '0;
      end else begin
        if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        case ({push_c, pop_c})
          2'b10:   fifo_cnt_q <= fifo_cnt_q + CNT_W'(1);
          2'b01:   fifo_cnt_q <= fifo_cnt_q - CNT_W'(1);
          default: fifo_cnt_q <= fifo_cnt_q;
        endcase
      end

      // Redirect beats stall; an empty FIFO inserts a NOP bubble
      if (bus.redir_valid) begin
        if_id_valid_q <= 1'b0;
        if_id_instr_q <= '0;
      end else if (!bus.id_stall) begin
        if (!empty_c) begin
          if_id_valid_q <= 1'b1;
          if_id_instr_q <= head_c.instr;
          if_id_pc_q    <= head_c.pc;
          if_id_pc4_q   <= head_c.pc + 32'd4;
        end else begin
          if_id_valid_q <= 1'b0;
          if_id_instr_q <= '0;
        end
      end
    end
  end

`ifdef FETCH_PERF_EN
  // Saturating counters; redirect does not clear them
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (push_c && perf_fetched != '1) perf_fetched <= perf_fetched + 32'd1;
      if (!bus.id_stall && empty_c && perf_bubbles != '1) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  // The credit rule must make push-on-full unreachable
  a_no_push_full: assert property (@(posedge clk) disable iff (!reset) !(push_c && full_c));
`endif

endmodule

// File: tb/tb_mips_fetch_stage.sv
// Directed bench for mips_fetch_stage: an in-order imem responder with
// configurable grant pattern and response delay; instruction words are the
// fetch address XOR KEY so instr and pc fields cannot be confused.
module tb_mips_fetch_stage;
  localparam logic [31:0] KEY = 32'hA5C3_0000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mips_fetch_stage_if bus();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  mips_fetch_stage #(
    .RESET_PC(32'h0000_0000),
    .FIFO_DEPTH(4),
    .MAX_OUTST(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_bubbles(perf_bubbles)
`endif
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_pc;
  bit stall_prev;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } rsp_t;
  rsp_t rq[$];
  int unsigned cyc = 0;
  bit gnt_rand = 1'b0;
  int unsigned dmin = 1, dmax = 1;

  // Record grants at the edge they happen
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (reset && bus.imem_req && bus.imem_gnt)
      rq.push_back('{bus.imem_addr, cyc + $urandom_range(dmax, dmin)});
  end

  // Drive grant and in-order responses for the next edge
  always @(negedge clk) begin
    bus.imem_gnt = gnt_rand ? 1'($urandom_range(1, 0)) : 1'b1;
    if (rq.size() > 0 && rq[0].due <= cyc + 1) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = rq[0].addr ^ KEY;
      void'(rq.pop_front());
    end else begin
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'hDEAD_BEEF;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic test_reset();
    reset = 1'b0;
    bus.redir_valid = 1'b0;
    bus.redir_pc = '0;
    bus.id_stall = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({bus.imem_req, bus.imem_addr} !== {1'b0, 32'h0})
      begin errors++; $display("FAIL reset_imem got req=%b addr=%h exp req=0 addr=0", bus.imem_req, bus.imem_addr); end
    checks++;
    if ({bus.if_id_valid, bus.if_id_instr, bus.if_id_pc, bus.if_id_pc4} !== {1'b0, 96'h0})
      begin errors++; $display("FAIL reset_ifid got v=%b i=%h pc=%h pc4=%h exp all 0", bus.if_id_valid, bus.if_id_instr, bus.if_id_pc, bus.if_id_pc4); end
    reset = 1'b1;
    stall_prev = 1'b0;
    exp_pc = 32'h0;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (bus.if_id_valid !== 1'b0)
        begin errors++; $display("FAIL stream_latency cycle %0d got valid=%b exp 0", i + 1, bus.if_id_valid); end
    end
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.if_id_valid, bus.if_id_pc, bus.if_id_instr, bus.if_id_pc4} !== {1'b1, exp_pc, exp_pc ^ KEY, exp_pc + 32'd4})
        begin errors++; $display("FAIL stream_seq got v=%b pc=%h i=%h pc4=%h exp pc=%h", bus.if_id_valid, bus.if_id_pc, bus.if_id_instr, bus.if_id_pc4, exp_pc); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_stall();
    logic [31:0] frozen;
    frozen = exp_pc - 32'd4;
    bus.id_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.if_id_valid, bus.if_id_pc} !== {1'b1, frozen})
        begin errors++; $display("FAIL stall_hold got v=%b pc=%h exp pc=%h", bus.if_id_valid, bus.if_id_pc, frozen); end
    end
    #1;
    checks++;
    if (bus.imem_req !== 1'b0)
      begin errors++; $display("FAIL stall_req_drop got req=%b exp 0", bus.imem_req); end
    bus.id_stall = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      checks++;
      if ({bus.if_id_valid, bus.if_id_pc, bus.if_id_instr, bus.if_id_pc4} !== {1'b1, exp_pc, exp_pc ^ KEY, exp_pc + 32'd4})
        begin errors++; $display("FAIL stall_drain got v=%b pc=%h i=%h pc4=%h exp pc=%h", bus.if_id_valid, bus.if_id_pc, bus.if_id_instr, bus.if_id_pc4, exp_pc); end
      exp_pc = exp_pc + 32'd4;
    end
    stall_prev = 1'b0;
  endtask

  task automatic test_redirect();
    bit found;
    dmin = 3; dmax = 3;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk); #1;
      if (bus.if_id_valid && !stall_prev) begin
        checks++;
        if ({bus.if_id_pc, bus.if_id_instr, bus.if_id_pc4} !== {exp_pc, exp_pc ^ KEY, exp_pc + 32'd4})
          begin errors++; $display("FAIL redir_pre got pc=%h i=%h exp pc=%h", bus.if_id_pc, bus.if_id_instr, exp_pc); end
        exp_pc = exp_pc + 32'd4;
      end
      if (rq.size() == 2 && !bus.imem_rvalid) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL redir_setup got inflight=%0d exp 2", rq.size()); end
    bus.redir_valid = 1'b1;
    bus.redir_pc = 32'h0000_0103;
    #1;
    checks++;
    if (bus.imem_req !== 1'b0)
      begin errors++; $display("FAIL redir_noreq got req=%b exp 0", bus.imem_req); end
    @(negedge clk);
    checks++;
    if ({bus.if_id_valid, bus.if_id_instr, bus.imem_addr} !== {1'b0, 32'h0, 32'h0000_0100})
      begin errors++; $display("FAIL redir_squash got v=%b i=%h addr=%h exp v=0 i=0 addr=100", bus.if_id_valid, bus.if_id_instr, bus.imem_addr); end
    bus.redir_valid = 1'b0;
    exp_pc = 32'h0000_0100;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.if_id_valid) found = 1'b1;
    end
    checks++;
    if (!found || {bus.if_id_pc, bus.if_id_pc4, bus.if_id_instr} !== {32'h100, 32'h104, 32'h100 ^ KEY})
      begin errors++; $display("FAIL redir_target got found=%b pc=%h pc4=%h exp pc=100 pc4=104", found, bus.if_id_pc, bus.if_id_pc4); end
    exp_pc = 32'h0000_0104;
  endtask

  task automatic test_redirect_stall();
    bit found;
    dmin = 1; dmax = 1;
    @(negedge clk);
    bus.id_stall = 1'b1;
    bus.redir_valid = 1'b1;
    bus.redir_pc = 32'h0000_0200;
    @(negedge clk);
    checks++;
    if ({bus.if_id_valid, bus.if_id_instr} !== {1'b0, 32'h0})
      begin errors++; $display("FAIL redir_over_stall got v=%b i=%h exp v=0 i=0", bus.if_id_valid, bus.if_id_instr); end
    bus.id_stall = 1'b0;
    bus.redir_valid = 1'b0;
    stall_prev = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.if_id_valid) found = 1'b1;
    end
    checks++;
    if (!found || bus.if_id_pc !== 32'h0000_0200)
      begin errors++; $display("FAIL redir_stall_target got found=%b pc=%h exp 200", found, bus.if_id_pc); end
    exp_pc = 32'h0000_0204;
  endtask

  task automatic test_back_to_back();
    bit found;
    dmin = 3; dmax = 3;
    repeat (5) @(negedge clk);
    bus.redir_valid = 1'b1;
    bus.redir_pc = 32'h0000_0300;
    @(negedge clk);
    bus.redir_pc = 32'h0000_0400;
    @(negedge clk);
    bus.redir_valid = 1'b0;
    exp_pc = 32'h0000_0400;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (bus.if_id_valid) found = 1'b1;
    end
    for (int i = 0; i < 12; i++) begin
      if (i > 0) @(negedge clk);
      if (bus.if_id_valid) begin
        checks++;
        if ({bus.if_id_pc, bus.if_id_instr, bus.if_id_pc4} !== {exp_pc, exp_pc ^ KEY, exp_pc + 32'd4})
          begin errors++; $display("FAIL b2b_seq got pc=%h i=%h pc4=%h exp pc=%h", bus.if_id_pc, bus.if_id_instr, bus.if_id_pc4, exp_pc); end
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++;
    if (!found || exp_pc == 32'h0000_0400)
      begin errors++; $display("FAIL b2b_progress got found=%b next_pc=%h exp beyond 400", found, exp_pc); end
  endtask

  task automatic test_wrap();
    bit found;
    dmin = 1; dmax = 1;
    @(negedge clk);
    bus.redir_valid = 1'b1;
    bus.redir_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    bus.redir_valid = 1'b0;
    exp_pc = 32'hFFFF_FFF8;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (bus.if_id_valid) found = 1'b1;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL wrap_timeout got no valid exp pc=fffffff8"); end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checks++;
      if ({bus.if_id_valid, bus.if_id_pc, bus.if_id_instr, bus.if_id_pc4} !== {1'b1, exp_pc, exp_pc ^ KEY, exp_pc + 32'd4})
        begin errors++; $display("FAIL wrap_seq got v=%b pc=%h i=%h pc4=%h exp pc=%h", bus.if_id_valid, bus.if_id_pc, bus.if_id_instr, bus.if_id_pc4, exp_pc); end
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  task automatic test_random();
    int unsigned got;
    gnt_rand = 1'b1;
    dmin = 1; dmax = 3;
    got = 0;
    stall_prev = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (bus.if_id_valid && !stall_prev) begin
        checks++;
        if ({bus.if_id_pc, bus.if_id_instr, bus.if_id_pc4} !== {exp_pc, exp_pc ^ KEY, exp_pc + 32'd4})
          begin errors++; $display("FAIL rand_seq got pc=%h i=%h pc4=%h exp pc=%h", bus.if_id_pc, bus.if_id_instr, bus.if_id_pc4, exp_pc); end
        exp_pc = exp_pc + 32'd4;
        got++;
      end else if (!bus.if_id_valid && !stall_prev) begin
        checks++;
        if (bus.if_id_instr !== 32'h0)
          begin errors++; $display("FAIL rand_bubble got i=%h exp 0", bus.if_id_instr); end
      end
      bus.id_stall = ($urandom_range(3, 0) == 0);
      stall_prev = bus.id_stall;
    end
    bus.id_stall = 1'b0;
    gnt_rand = 1'b0;
    checks++;
    if (got < 30) begin errors++; $display("FAIL rand_progress got %0d words exp >=30", got); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_back_to_back();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
